// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared types and constants for the pipelined RISC-V core
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  typedef enum logic [1:0] {
    FS_RESET = 2'd0,
    FS_BOOT  = 2'd1,
    FS_RUN   = 2'd2
  } fetch_state_e;

  localparam if_id_t IFID_RESET = '{valid: 1'b0, instr: NOP_INSTR, pc: '0, pc_plus4: '0};

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// fetch_stage_if : instruction-memory, hazard/redirect and IF/ID bundle
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic [XLEN-3:0]  imem_addr;
  logic [31:0]      imem_instr;
  logic             stall;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             ifid_valid;
  logic [31:0]      ifid_instr;
  logic [XLEN-1:0]  ifid_pc;
  logic [XLEN-1:0]  ifid_pc_plus4;
  logic             misalign;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, misalign, fetch_count,
    input  imem_instr, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, misalign, fetch_count,
    output imem_instr, stall, redirect, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// if_id_reg : IF/ID pipeline register with hold and flush-to-bubble
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t ifid_q;

  // Flush only kills valid/instr; the PC fields keep their last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifid_q <= IFID_RESET;
    end else if (flush_i) begin
      ifid_q.valid <= 1'b0;
      ifid_q.instr <= NOP_INSTR;
    end else if (load_i) begin
      ifid_q <= d_i;
    end
  end

  assign q_o = ifid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : IF stage (PC, next-PC mux, boot FSM, fetch counter) + IF/ID
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int                 XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]    RESET_PC = '0,
  parameter int                 CNT_W    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.master bus
);
  import riscv_pkg::*;

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic             misalign_q, misalign_d;

  logic             run_w;
  logic             do_redirect_w;
  logic             do_fetch_w;
  logic [XLEN-1:0]  pc_plus4_w;
  if_id_t           ifid_d_w;
  if_id_t           ifid_q_w;

  assign run_w         = (state_q == FS_RUN);
  assign do_redirect_w = run_w && bus.redirect;
  assign do_fetch_w    = run_w && !bus.redirect && !bus.stall;
  assign pc_plus4_w    = pc_q + XLEN'(4);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FS_RESET;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
    end
  end

  // Redirect beats stall; both are ignored until the FSM reaches RUN.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = 1'b0;
    case (state_q)
      FS_RESET: state_d = FS_BOOT;
      FS_BOOT:  state_d = FS_RUN;
      FS_RUN: begin
        state_d = FS_RUN;
        if (do_redirect_w) begin
          pc_d       = {bus.redirect_pc[XLEN-1:2], 2'b00};
          misalign_d = |bus.redirect_pc[1:0];
        end else if (do_fetch_w) begin
          pc_d          = pc_plus4_w;
          fetch_count_d = fetch_count_q + CNT_W'(1);
        end
      end
      default:  state_d = FS_RESET;
    endcase
  end

  assign ifid_d_w = '{valid: 1'b1, instr: bus.imem_instr, pc: pc_q, pc_plus4: pc_plus4_w};

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (do_fetch_w),
    .flush_i (do_redirect_w),
    .d_i     (ifid_d_w),
    .q_o     (ifid_q_w)
  );

  assign bus.imem_addr     = pc_q[XLEN-1:2];
  assign bus.ifid_valid    = ifid_q_w.valid;
  assign bus.ifid_instr    = ifid_q_w.instr;
  assign bus.ifid_pc       = ifid_q_w.pc;
  assign bus.ifid_pc_plus4 = ifid_q_w.pc_plus4;
  assign bus.misalign      = misalign_q;
  assign bus.fetch_count   = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : directed self-checking bench for fetch_stage
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  fetch_stage_if #(.XLEN(64), .CNT_W(32)) bus ();

  fetch_stage #(.XLEN(64), .RESET_PC(64'h0), .CNT_W(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  function automatic logic [31:0] imem_model(input logic [61:0] a);
    if (a == 62'd0)      return 32'h0050_0093;
    else if (a == 62'd1) return 32'h00a0_0113;
    else                 return {a[24:0], 7'h13};
  endfunction

  assign bus.imem_instr = imem_model(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    repeat (2) @(negedge clk);
    total++; if (bus.imem_addr !== 62'd0) begin $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); bad++; end
    total++; if (bus.ifid_valid !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", bus.ifid_valid); bad++; end
    total++; if (bus.ifid_instr !== NOP) begin $display("FAIL rst_instr got=%h exp=%h", bus.ifid_instr, NOP); bad++; end
    total++; if (bus.ifid_pc !== 64'h0 || bus.ifid_pc_plus4 !== 64'h0) begin $display("FAIL rst_pc got=%h/%h exp=0/0", bus.ifid_pc, bus.ifid_pc_plus4); bad++; end
    total++; if (bus.misalign !== 1'b0 || bus.fetch_count !== 32'd0) begin $display("FAIL rst_misc got=%b/%0d exp=0/0", bus.misalign, bus.fetch_count); bad++; end
    reset_n = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      total++; if (bus.imem_addr !== 62'd0 || bus.ifid_valid !== 1'b0) begin $display("FAIL boot_edge%0d got=addr %h valid %b exp=0/0", e, bus.imem_addr, bus.ifid_valid); bad++; end
    end
  endtask

  task automatic test_sequential();
    @(negedge clk);
    total++; if (bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 32'h0050_0093) begin $display("FAIL seq0_instr got=%b/%h exp=1/00500093", bus.ifid_valid, bus.ifid_instr); bad++; end
    total++; if (bus.ifid_pc !== 64'h0 || bus.ifid_pc_plus4 !== 64'h4) begin $display("FAIL seq0_pc got=%h/%h exp=0/4", bus.ifid_pc, bus.ifid_pc_plus4); bad++; end
    total++; if (bus.fetch_count !== 32'd1 || bus.imem_addr !== 62'd1) begin $display("FAIL seq0_cnt got=%0d/%h exp=1/1", bus.fetch_count, bus.imem_addr); bad++; end
    @(negedge clk);
    total++; if (bus.ifid_instr !== 32'h00a0_0113) begin $display("FAIL seq1_instr got=%h exp=00a00113", bus.ifid_instr); bad++; end
    total++; if (bus.ifid_pc !== 64'h4 || bus.ifid_pc_plus4 !== 64'h8) begin $display("FAIL seq1_pc got=%h/%h exp=4/8", bus.ifid_pc, bus.ifid_pc_plus4); bad++; end
    total++; if (bus.fetch_count !== 32'd2 || bus.imem_addr !== 62'd2) begin $display("FAIL seq1_cnt got=%0d/%h exp=2/2", bus.fetch_count, bus.imem_addr); bad++; end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.imem_addr !== 62'd2 || bus.ifid_pc !== 64'h4 || bus.fetch_count !== 32'd2 || bus.ifid_valid !== 1'b1) begin
        $display("FAIL stall_hold%0d got=addr %h pc %h cnt %0d v %b exp=2/4/2/1", c, bus.imem_addr, bus.ifid_pc, bus.fetch_count, bus.ifid_valid); bad++; end
    end
    bus.stall = 1'b0;
    @(negedge clk);
    total++; if (bus.ifid_pc !== 64'h8 || bus.ifid_instr !== 32'h0000_0113 || bus.fetch_count !== 32'd3 || bus.imem_addr !== 62'd3) begin
      $display("FAIL stall_resume got=pc %h instr %h cnt %0d addr %h exp=8/00000113/3/3", bus.ifid_pc, bus.ifid_instr, bus.fetch_count, bus.imem_addr); bad++; end
    @(negedge clk);
    total++; if (bus.ifid_pc !== 64'hC || bus.ifid_pc_plus4 !== 64'h10 || bus.fetch_count !== 32'd4) begin
      $display("FAIL stall_next got=pc %h p4 %h cnt %0d exp=c/10/4", bus.ifid_pc, bus.ifid_pc_plus4, bus.fetch_count); bad++; end
  endtask

  task automatic test_redirect_stall();
    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 64'h40;
    @(negedge clk);
    total++; if (bus.imem_addr !== 62'h10 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== NOP) begin
      $display("FAIL redir_flush got=addr %h v %b instr %h exp=10/0/%h", bus.imem_addr, bus.ifid_valid, bus.ifid_instr, NOP); bad++; end
    total++; if (bus.fetch_count !== 32'd4 || bus.misalign !== 1'b0) begin $display("FAIL redir_cnt got=%0d/%b exp=4/0", bus.fetch_count, bus.misalign); bad++; end
    bus.stall = 1'b0; bus.redirect = 1'b0;
    @(negedge clk);
    total++; if (bus.ifid_pc !== 64'h40 || bus.ifid_pc_plus4 !== 64'h44 || bus.ifid_valid !== 1'b1 || bus.fetch_count !== 32'd5) begin
      $display("FAIL redir_target got=pc %h p4 %h v %b cnt %0d exp=40/44/1/5", bus.ifid_pc, bus.ifid_pc_plus4, bus.ifid_valid, bus.fetch_count); bad++; end
  endtask

  task automatic test_misalign();
    bus.redirect = 1'b1; bus.redirect_pc = 64'h42;
    @(negedge clk);
    total++; if (bus.imem_addr !== 62'h10 || bus.misalign !== 1'b1 || bus.ifid_valid !== 1'b0) begin
      $display("FAIL mis_pulse got=addr %h mis %b v %b exp=10/1/0", bus.imem_addr, bus.misalign, bus.ifid_valid); bad++; end
    bus.redirect = 1'b0;
    @(negedge clk);
    total++; if (bus.misalign !== 1'b0 || bus.ifid_pc !== 64'h40 || bus.fetch_count !== 32'd6) begin
      $display("FAIL mis_clear got=mis %b pc %h cnt %0d exp=0/40/6", bus.misalign, bus.ifid_pc, bus.fetch_count); bad++; end
  endtask

  task automatic test_async_reset();
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus.imem_addr !== 62'd0 || bus.ifid_valid !== 1'b0 || bus.ifid_instr !== NOP) begin
      $display("FAIL arst_ifid got=addr %h v %b instr %h exp=0/0/%h", bus.imem_addr, bus.ifid_valid, bus.ifid_instr, NOP); bad++; end
    total++; if (bus.ifid_pc !== 64'h0 || bus.ifid_pc_plus4 !== 64'h0 || bus.fetch_count !== 32'd0 || bus.misalign !== 1'b0) begin
      $display("FAIL arst_misc got=pc %h p4 %h cnt %0d mis %b exp=0/0/0/0", bus.ifid_pc, bus.ifid_pc_plus4, bus.fetch_count, bus.misalign); bad++; end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_boot_ignore_and_wrap();
    bus.redirect = 1'b1; bus.redirect_pc = 64'h81;
    for (int e = 1; e <= 2; e++) begin
      @(negedge clk);
      total++; if (bus.imem_addr !== 62'd0 || bus.misalign !== 1'b0 || bus.ifid_valid !== 1'b0) begin
        $display("FAIL boot_ignore%0d got=addr %h mis %b v %b exp=0/0/0", e, bus.imem_addr, bus.misalign, bus.ifid_valid); bad++; end
    end
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    total++; if (bus.imem_addr !== 62'h3FFF_FFFF_FFFF_FFFF || bus.fetch_count !== 32'd0) begin
      $display("FAIL wrap_redir got=addr %h cnt %0d exp=3fffffffffffffff/0", bus.imem_addr, bus.fetch_count); bad++; end
    bus.redirect = 1'b0;
    @(negedge clk);
    total++; if (bus.ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.ifid_pc_plus4 !== 64'h0 || bus.imem_addr !== 62'd0 || bus.fetch_count !== 32'd1) begin
      $display("FAIL wrap_fetch got=pc %h p4 %h addr %h cnt %0d exp=fffffffffffffffc/0/0/1", bus.ifid_pc, bus.ifid_pc_plus4, bus.imem_addr, bus.fetch_count); bad++; end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_misalign();
    test_async_reset();
    test_boot_ignore_and_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
